mvm_result_writer: RTL and testbench

Write-back end of the MVM datapath. It takes a snapshot of the NUM_MAC accumulator results when the MVM signals completion. It then drains them one word per accepted transfer into result memory through a simple write-master interface with waitrequest backpressure. This is the counterpart of the row-fetch path that fills the MAC FIFOs from memory.

---
 rtl/mvm_result_writer.sv | 126 ++++++++++++
 tb/tb_mvm_result_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mvm_result_writer.sv
// Captures NUM_MAC accumulator results on start and writes them out one word per accepted transfer.
// Latency: first write request 1 cycle after start; done pulses 1 cycle after the final acceptance.
// Backpressure: wr_waitrequest holds address/data/write stable. Optional checksum word via MVM_WB_CHECKSUM_EN.
module mvm_result_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MAC    = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH * 3,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_MAC*ACC_WIDTH-1:0]   result_flat,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    output logic [ADDR_WIDTH-1:0]          wr_address,
    output logic                           wr_write,
    output logic [WORD_WIDTH-1:0]          wr_writedata,
    input  logic                           wr_waitrequest,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MAC - 1);

`ifdef MVM_WB_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CHKSUM, S_DONE} state_t;
    logic [WORD_WIDTH-1:0] chk_sum;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

    state_t               state;
    logic [IDX_W-1:0]     index;
    logic [ACC_WIDTH-1:0] shadow [NUM_MAC];
    logic                 accept;

    assign accept = wr_write && !wr_waitrequest;

    // Snapshot is only taken from IDLE, so a start mid-pass cannot disturb the words being drained.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && start) begin
            for (int i = 0; i < NUM_MAC; i++) begin
                shadow[i] <= result_flat[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    // wr_address doubles as the latched base: it starts at base_addr and steps by one per acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            index        <= '0;
            wr_write     <= 1'b0;
            wr_address   <= '0;
            wr_writedata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef MVM_WB_CHECKSUM_EN
            chk_sum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= S_WRITE;
                        index        <= '0;
                        busy         <= 1'b1;
                        wr_write     <= 1'b1;
                        wr_address   <= base_addr;
                        wr_writedata <= WORD_WIDTH'(result_flat[0 +: ACC_WIDTH]);
`ifdef MVM_WB_CHECKSUM_EN
                        chk_sum      <= '0;
`endif
                    end
                end
                S_WRITE: begin
                    if (accept) begin
`ifdef MVM_WB_CHECKSUM_EN
                        chk_sum <= chk_sum + wr_writedata;
`endif
                        if (index == LAST_IDX) begin
`ifdef MVM_WB_CHECKSUM_EN
                            state        <= S_CHKSUM;
                            wr_address   <= wr_address + ADDR_WIDTH'(1);
                            wr_writedata <= chk_sum + wr_writedata;
`else
                            state        <= S_DONE;
                            wr_write     <= 1'b0;
                            done         <= 1'b1;
`endif
                        end else begin
                            index        <= index + IDX_W'(1);
                            wr_address   <= wr_address + ADDR_WIDTH'(1);
                            wr_writedata <= WORD_WIDTH'(shadow[index + IDX_W'(1)]);
                        end
                    end
                end
`ifdef MVM_WB_CHECKSUM_EN
                S_CHKSUM: begin
                    if (accept) begin
                        state    <= S_DONE;
                        wr_write <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    index <= '0;
                end
                default: begin
                    state    <= S_IDLE;
                    wr_write <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_result_writer.sv
// Directed bench for mvm_result_writer: drain order, stalls, address wrap, ignored start, reset, checksum.
module tb_mvm_result_writer;

    localparam int NUM_MAC = 8;
    localparam int ACC_W   = 24;
`ifdef MVM_WB_CHECKSUM_EN
    localparam int NW = NUM_MAC + 1;
`else
    localparam int NW = NUM_MAC;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [NUM_MAC*ACC_W-1:0] result_flat;
    logic [7:0]               base_addr;
    logic [7:0]               wr_address;
    logic                     wr_write;
    logic [31:0]              wr_writedata;
    logic                     wr_waitrequest;
    logic                     busy;
    logic                     done;

    int checks = 0;
    int errors = 0;

    mvm_result_writer #(
        .DATA_WIDTH(8), .NUM_MAC(NUM_MAC), .ACC_WIDTH(ACC_W), .WORD_WIDTH(32), .ADDR_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .result_flat(result_flat), .base_addr(base_addr),
        .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
        .wr_waitrequest(wr_waitrequest), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one pass from start, checking every presented word and the done timing.
    task automatic drain(input logic [7:0] base, input logic [ACC_W-1:0] res [NUM_MAC],
                         input int stall_k, input int stall_n, input bit disturb);
        logic [31:0] exp [NW];
        logic [31:0] sum;
        logic [7:0]  a;
        int          cyc;
        int          nw;
        int          stalls;
        bit          finished;
        sum = 32'd0;
        for (int i = 0; i < NUM_MAC; i++) begin
            exp[i] = 32'(res[i]);
            sum    = sum + 32'(res[i]);
            result_flat[i*ACC_W +: ACC_W] = res[i];
        end
`ifdef MVM_WB_CHECKSUM_EN
        exp[NUM_MAC] = sum;
`endif
        base_addr      = base;
        wr_waitrequest = 1'b0;
        start          = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = 8'h55;
        cyc = 1; nw = 0; stalls = 0; finished = 1'b0;
        for (int guard = 0; guard < 100; guard++) begin
            if (disturb && cyc == 4) begin
                start       = 1'b1;
                result_flat = {NUM_MAC{24'hAAAAAA}};
            end else begin
                start = 1'b0;
            end
            if (wr_write) begin
                if (nw < NW) begin
                    a = base + 8'(nw);
                    check("wr_address", 32'(wr_address), 32'(a));
                    check("wr_writedata", wr_writedata, exp[nw]);
                end else begin
                    check("extra_write", 32'(nw), 32'(NW - 1));
                end
                check("busy_during_write", 32'(busy), 32'd1);
                if (nw == stall_k && stalls < stall_n) begin
                    wr_waitrequest = 1'b1;
                    stalls++;
                end else begin
                    wr_waitrequest = 1'b0;
                    nw++;
                end
            end else begin
                wr_waitrequest = 1'b0;
            end
            if (done) begin
                check("done_cycle", 32'(cyc), 32'(NW + 1 + stall_n));
                check("write_count", 32'(nw), 32'(NW));
                check("busy_at_done", 32'(busy), 32'd1);
                if (disturb) start = 1'b1;
                finished = 1'b1;
                tick();
                start = 1'b0;
                check("done_one_cycle", 32'(done), 32'd0);
                check("busy_after_done", 32'(busy), 32'd0);
                check("no_write_after_done", 32'(wr_write), 32'd0);
                tick();
                check("idle_stays_quiet", 32'(wr_write), 32'd0);
                break;
            end
            tick();
            cyc++;
        end
        if (!finished) check("done_timeout", 32'd0, 32'd1);
    endtask

    logic [ACC_W-1:0] seq  [NUM_MAC];
    logic [ACC_W-1:0] wrap [NUM_MAC];

    initial begin
        rst = 1'b1; start = 1'b0; result_flat = '0; base_addr = 8'h00; wr_waitrequest = 1'b0;
        for (int i = 0; i < NUM_MAC; i++) begin
            seq[i]  = ACC_W'(i + 1);
            wrap[i] = '0;
        end
        wrap[0] = 24'hFFFFFF;
        tick();
        tick();
        check("rst_wr_write", 32'(wr_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_address", 32'(wr_address), 32'd0);
        check("rst_wr_writedata", wr_writedata, 32'd0);
        rst = 1'b0;
        tick();

        drain(8'h10, seq, 0, 0, 1'b0);      // basic drain
        drain(8'h10, seq, 2, 3, 1'b0);      // 3-cycle stall on the third word
        drain(8'hFE, wrap, 0, 0, 1'b0);     // address wrap, full-width data
        drain(8'h20, seq, 0, 0, 1'b1);      // start pulses and input change mid-pass
        drain(8'h40, seq, 5, 2, 1'b1);      // stall combined with disturbance

        // Reset during the fifth write abandons the pass.
        for (int i = 0; i < NUM_MAC; i++) result_flat[i*ACC_W +: ACC_W] = seq[i];
        base_addr = 8'h30;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        check("pre_rst_write", 32'(wr_write), 32'd1);
        check("pre_rst_addr", 32'(wr_address), 32'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_wr_write", 32'(wr_write), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_address", 32'(wr_address), 32'd0);
        for (int c = 0; c < 6; c++) begin
            check("midrst_no_done", 32'(done), 32'd0);
            check("midrst_no_write", 32'(wr_write), 32'd0);
            tick();
        end
        drain(8'h10, seq, 0, 0, 1'b0);      // fresh pass after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
